adrv9001_tdd_sequencer: RTL
===========================

Name: adrv9001_tdd_sequencer

Overview:
- Per-channel TDD timing controller for one ADRV9001 RX/TX channel pair; instantiated once per channel.
- Runs a programmable frame counter and drives the transceiver enable pins (rx_en/tx_en) and the datapath resets for the adrv9001_rx / adrv9001_tx instances.
- Configuration comes from the register block; the block runs in the AXI register clock domain.

Parameters:
- CNT_WIDTH, 24, width of frame counter and all window timing fields.
- SETTLE_WIDTH, 16, width of the enable-to-datapath-release settle delay.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin sequencing.
- stop  in  1  one-cycle pulse; finish current frame, then idle.
- abort  in  1  one-cycle pulse; idle immediately.
- oneshot  in  1  1 = run exactly one frame.
- frame_len  in  CNT_WIDTH  frame length in cycles.
- rx_on, rx_off  in  CNT_WIDTH  RX window [rx_on, rx_off) in counter units.
- tx_on, tx_off  in  CNT_WIDTH  TX window [tx_on, tx_off).
- settle  in  SETTLE_WIDTH  cycles from enable rise to reset release.
- rx_en, tx_en  out  1  transceiver enable pins.
- rx_rst, tx_rst  out  1  active-high datapath resets.
- busy  out  1  state != IDLE.
- frame_strobe  out  1  one-cycle pulse on the last cycle of each frame.
- frame_count  out  16  completed frames since start; wraps at 0xFFFF->0.
- cfg_err  out  1  sticky config error; cleared by the next accepted start.

Behaviour:
- Reset values:
  - rx_en = tx_en = busy = frame_strobe = cfg_err = 0.
  - rx_rst = tx_rst = 1.
  - frame_count = 0, state = IDLE, internal counter = 0.
- States:
  - IDLE -> RUN on start when the configuration is valid.
  - RUN -> DRAIN on stop, or when oneshot is latched.
  - DRAIN -> IDLE at the frame's last cycle.
  - Any state -> IDLE on abort.
- Configuration is invalid if any of these hold:
  - frame_len == 0;
  - rx_on > rx_off, or tx_on > tx_off;
  - either off value > frame_len;
  - the RX and TX windows overlap.
- Invalid start: start is ignored, cfg_err is set, state stays IDLE.
- Config latching:
  - All timing inputs plus oneshot are latched on the accepted start.
  - They are re-latched on each frame wrap while in RUN, so changes apply only at frame boundaries.
  - A re-latch that would be invalid keeps the old config and sets cfg_err.
- Start timing: start accepted in cycle T; cnt = 0 and busy = 1 from T+1.
- Counter: cnt increments every cycle in RUN/DRAIN; at cnt == frame_len-1 it wraps to 0.
- Enables:
  - rx_en(t+1) = (state RUN or DRAIN) && rx_on <= cnt(t) < rx_off. tx_en is identical with tx_on/tx_off.
  - Enable latency from counter is 1 cycle.
  - rx_on == rx_off means the RX window is empty; same for TX.
- frame_strobe(t+1) = 1 when cnt(t) == frame_len-1.
- frame_count increments with frame_strobe; it clears on an accepted start.
- Resets:
  - rx_rst = 1 whenever rx_en = 0 (it follows rx_en's fall in the same cycle).
  - After rx_en rises, rx_rst falls once rx_en has been high settle+1 cycles; settle = 0 gives release 1 cycle after rx_en rise.
  - If the window closes before the settle delay ends, rx_rst never drops.
  - tx_rst follows the same rules against tx_en.
- Simultaneous events:
  - abort has priority over stop and start.
  - stop has priority over start; start+stop in IDLE is ignored.
  - start in RUN/DRAIN is ignored.
  - stop in DRAIN has no further effect.
- Abort: next cycle gives state IDLE, rx_en = tx_en = 0, rx_rst = tx_rst = 1, cnt = 0, busy = 0. frame_count holds its value.
- DRAIN exit: the final frame completes and frame_strobe fires. IDLE follows on the next cycle, with all outputs at their idle values.
- frame_len == 1: cnt is always 0 and frame_strobe stays high continuously.
- An asynchronous reset mid-operation forces all reset values immediately.

Test Plan:
- Basic frame:
  - Stimulus: frame_len=100, rx=[10,40), tx=[50,90), settle=3, start.
  - Required: rx_en high cycles T+12..T+41; rx_rst low T+16..T+41; tx_en high T+52..T+91; frame_strobe at T+101 and every 100 cycles thereafter.
- Overlapping windows:
  - Stimulus: rx=[10,60), tx=[50,90), start.
  - Required: cfg_err=1, busy stays 0, all enables 0.
  - Then a valid start clears cfg_err and runs.
- Stop vs abort:
  - Stimulus: stop at cnt=30 in frame 3.
  - Required: frame completes, frame_count=4, busy drops 1 cycle after the strobe.
  - Repeat with abort at cnt=30: enables 0 and rx_rst=1 the next cycle, frame_count=3.
- Oneshot with reconfig:
  - Stimulus: oneshot=1, frame_len=20.
  - Required: exactly one frame_strobe, frame_count=1, then idle.
  - In continuous mode, changing rx_on mid-frame takes effect only in the next frame.
- Short window and settle:
  - Stimulus: rx=[10,12), settle=5.
  - Required: rx_en high 2 cycles, rx_rst never deasserts.
  - Stimulus: settle=0.
  - Required: rx_rst falls 1 cycle after rx_en rise.
- Wraps and priority:
  - Stimulus: frame_count at 0xFFFF, then one more frame; separately, start+stop asserted together in IDLE; separately, async reset mid-frame.
  - Required: frame_count wraps to 0; start+stop in IDLE is ignored; async reset gives all reset values immediately.

Source files
------------

// File: rtl/adrv9001_tdd_sequencer_if.sv
// Control/status bundle between the register block and one TDD sequencer channel.
// The register block drives timing and commands; the sequencer returns pin and status state.
interface adrv9001_tdd_sequencer_if #(
    parameter int CNT_WIDTH    = 24,
    parameter int SETTLE_WIDTH = 16
);
    logic                    start;
    logic                    stop;
    logic                    abort;
    logic                    oneshot;
    logic [CNT_WIDTH-1:0]    frame_len;
    logic [CNT_WIDTH-1:0]    rx_on;
    logic [CNT_WIDTH-1:0]    rx_off;
    logic [CNT_WIDTH-1:0]    tx_on;
    logic [CNT_WIDTH-1:0]    tx_off;
    logic [SETTLE_WIDTH-1:0] settle;
    logic                    rx_en;
    logic                    tx_en;
    logic                    rx_rst;
    logic                    tx_rst;
    logic                    busy;
    logic                    frame_strobe;
    logic [15:0]             frame_count;
    logic                    cfg_err;

    modport master (
        output start, stop, abort, oneshot, frame_len, rx_on, rx_off, tx_on, tx_off, settle,
        input  rx_en, tx_en, rx_rst, tx_rst, busy, frame_strobe, frame_count, cfg_err
    );

    modport slave (
        input  start, stop, abort, oneshot, frame_len, rx_on, rx_off, tx_on, tx_off, settle,
        output rx_en, tx_en, rx_rst, tx_rst, busy, frame_strobe, frame_count, cfg_err
    );
endinterface

// File: rtl/adrv9001_tdd_sequencer.sv
// Per-channel TDD frame sequencer: frame counter, RX/TX enable windows and
// settle-delayed datapath reset release, all in the register clock domain.
module adrv9001_tdd_sequencer #(
    parameter int CNT_WIDTH    = 24,
    parameter int SETTLE_WIDTH = 16
) (
    input  logic s_axi_aclk,
    input  logic s_axi_aresetn,
    adrv9001_tdd_sequencer_if.slave tdd
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic                    oneshot;
        logic [SETTLE_WIDTH-1:0] settle;
        logic [CNT_WIDTH-1:0]    frame_len;
        logic [CNT_WIDTH-1:0]    rx_on;
        logic [CNT_WIDTH-1:0]    rx_off;
        logic [CNT_WIDTH-1:0]    tx_on;
        logic [CNT_WIDTH-1:0]    tx_off;
    } cfg_t;

    // Empty windows (on == off) never count as overlapping.
    function automatic logic cfg_ok(input cfg_t c);
        logic rx_nz;
        logic tx_nz;
        logic ovl;
        rx_nz = (c.rx_on != c.rx_off);
        tx_nz = (c.tx_on != c.tx_off);
        ovl   = rx_nz && tx_nz && (c.rx_on < c.tx_off) && (c.tx_on < c.rx_off);
        return (c.frame_len != '0) && (c.rx_on <= c.rx_off) && (c.tx_on <= c.tx_off) &&
               (c.rx_off <= c.frame_len) && (c.tx_off <= c.frame_len) && !ovl;
    endfunction

    state_t                  r_state;
    cfg_t                    r_cfg;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_fin;
    logic                    r_rx_en;
    logic                    r_tx_en;
    logic                    r_rx_rst;
    logic                    r_tx_rst;
    logic [SETTLE_WIDTH-1:0] r_rx_hi;
    logic [SETTLE_WIDTH-1:0] r_tx_hi;
    logic                    r_strobe;
    logic [15:0]             r_frame_count;
    logic                    r_cfg_err;

    cfg_t w_cfg_in;
    logic w_cfg_ok;
    logic w_last;
    logic w_active;
    logic w_finish;
    logic w_rx_en_nxt;
    logic w_tx_en_nxt;
    logic w_strobe_nxt;

    always_comb begin
        w_cfg_in           = '0;
        w_cfg_in.oneshot   = tdd.oneshot;
        w_cfg_in.settle    = tdd.settle;
        w_cfg_in.frame_len = tdd.frame_len;
        w_cfg_in.rx_on     = tdd.rx_on;
        w_cfg_in.rx_off    = tdd.rx_off;
        w_cfg_in.tx_on     = tdd.tx_on;
        w_cfg_in.tx_off    = tdd.tx_off;
    end

    assign w_cfg_ok = cfg_ok(w_cfg_in);
    assign w_last   = (r_cnt == r_cfg.frame_len - CNT_WIDTH'(1));
    // r_fin marks the strobe cycle after the final DRAIN frame: still busy, but no longer counting.
    assign w_active = (r_state == RUN) || ((r_state == DRAIN) && !r_fin);
    assign w_finish = w_active && w_last && ((r_state == DRAIN) || tdd.stop || r_cfg.oneshot);

    assign w_rx_en_nxt  = w_active && !tdd.abort && (r_cfg.rx_on <= r_cnt) && (r_cnt < r_cfg.rx_off);
    assign w_tx_en_nxt  = w_active && !tdd.abort && (r_cfg.tx_on <= r_cnt) && (r_cnt < r_cfg.tx_off);
    assign w_strobe_nxt = w_active && !tdd.abort && w_last;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state       <= IDLE;
            r_cfg         <= '0;
            r_cnt         <= '0;
            r_fin         <= 1'b0;
            r_rx_en       <= 1'b0;
            r_tx_en       <= 1'b0;
            r_rx_rst      <= 1'b1;
            r_tx_rst      <= 1'b1;
            r_rx_hi       <= '0;
            r_tx_hi       <= '0;
            r_strobe      <= 1'b0;
            r_frame_count <= '0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_rx_en  <= w_rx_en_nxt;
            r_tx_en  <= w_tx_en_nxt;
            r_strobe <= w_strobe_nxt;
            if (w_strobe_nxt)
                r_frame_count <= r_frame_count + 16'd1;

            // r_*_hi counts completed high cycles of the enable, saturating at settle.
            if (!w_rx_en_nxt)
                r_rx_rst <= 1'b1;
            else if (r_rx_en && (r_rx_hi >= r_cfg.settle))
                r_rx_rst <= 1'b0;
            if (!r_rx_en)
                r_rx_hi <= '0;
            else if (r_rx_hi < r_cfg.settle)
                r_rx_hi <= r_rx_hi + SETTLE_WIDTH'(1);

            if (!w_tx_en_nxt)
                r_tx_rst <= 1'b1;
            else if (r_tx_en && (r_tx_hi >= r_cfg.settle))
                r_tx_rst <= 1'b0;
            if (!r_tx_en)
                r_tx_hi <= '0;
            else if (r_tx_hi < r_cfg.settle)
                r_tx_hi <= r_tx_hi + SETTLE_WIDTH'(1);

            if (tdd.abort) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_fin   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (tdd.start && !tdd.stop) begin
                            if (w_cfg_ok) begin
                                r_state       <= RUN;
                                r_cfg         <= w_cfg_in;
                                r_cfg_err     <= 1'b0;
                                r_frame_count <= '0;
                                r_cnt         <= '0;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    RUN, DRAIN: begin
                        if (r_fin) begin
                            r_state <= IDLE;
                            r_fin   <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_last ? '0 : r_cnt + CNT_WIDTH'(1);
                            if (w_finish) begin
                                r_state <= DRAIN;
                                r_fin   <= 1'b1;
                            end else if (r_state == RUN) begin
                                if (tdd.stop || r_cfg.oneshot)
                                    r_state <= DRAIN;
                                // Frame boundary: adopt new timing only if it is consistent.
                                if (w_last) begin
                                    if (w_cfg_ok)
                                        r_cfg <= w_cfg_in;
                                    else
                                        r_cfg_err <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tdd.rx_en        = r_rx_en;
    assign tdd.tx_en        = r_tx_en;
    assign tdd.rx_rst       = r_rx_rst;
    assign tdd.tx_rst       = r_tx_rst;
    assign tdd.busy         = (r_state != IDLE);
    assign tdd.frame_strobe = r_strobe;
    assign tdd.frame_count  = r_frame_count;
    assign tdd.cfg_err      = r_cfg_err;

endmodule
